// File: rtl/rfid_inv_pkg.sv
// Shared encodings for the interrogator-side inventory round controller.
// Holds command, up/down and slot-result codes, the controller state enum
// and the upper bound of the quarter-step Q accumulator.
package rfid_inv_pkg;

  localparam logic [1:0] CMD_QUERY       = 2'd0;
  localparam logic [1:0] CMD_QUERYREP    = 2'd1;
  localparam logic [1:0] CMD_QUERYADJUST = 2'd2;

  localparam logic [1:0] UPDN_NONE = 2'b00;
  localparam logic [1:0] UPDN_UP   = 2'b01;
  localparam logic [1:0] UPDN_DOWN = 2'b10;

  localparam logic [1:0] SLOT_EMPTY  = 2'd0;
  localparam logic [1:0] SLOT_SINGLE = 2'd1;
  localparam logic [1:0] SLOT_COLL   = 2'd2;

  // Qfp is Q in quarter units; 60 corresponds to Q=15.
  localparam logic [5:0] QFP_MAX = 6'd60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_UPDATE,
    ST_DONE
  } inv_state_e;

endpackage

// File: rtl/q_adjust_calc.sv
// Purpose: per-slot Q adaptation; new Qfp from the slot outcome, then the next command.
// Latency: purely combinational. Backpressure: none (no handshake).
// Ports: i_qfp/i_q current accumulator and committed Q, i_result slot outcome;
//        o_qfp_nxt updated accumulator, o_cmd_type/o_updn/o_q_nxt next command.
module q_adjust_calc
  import rfid_inv_pkg::*;
#(
  parameter int C_QTR = 1
) (
  input  logic [5:0] i_qfp,
  input  logic [3:0] i_q,
  input  logic [1:0] i_result,
  output logic [5:0] o_qfp_nxt,
  output logic [1:0] o_cmd_type,
  output logic [1:0] o_updn,
  output logic [3:0] o_q_nxt
);

  localparam logic [6:0] C_STEP = 7'(C_QTR);

  logic [6:0] w_sum;
  logic [4:0] w_qr;
  logic [3:0] w_qr_sat;

  assign w_sum = {1'b0, i_qfp} + C_STEP;

  always_comb begin
    o_qfp_nxt = i_qfp;
    case (i_result)
      SLOT_EMPTY:  o_qfp_nxt = ({1'b0, i_qfp} >= C_STEP) ? (i_qfp - C_STEP[5:0]) : 6'd0;
      SLOT_SINGLE: o_qfp_nxt = i_qfp;
      // Collision and the reserved code both push Q upward.
      default:     o_qfp_nxt = (w_sum > {1'b0, QFP_MAX}) ? QFP_MAX : w_sum[5:0];
    endcase
  end

  // Round-half-up of Qfp/4: integer part plus the half-unit bit.
  assign w_qr     = {1'b0, o_qfp_nxt[5:2]} + {4'd0, o_qfp_nxt[1]};
  assign w_qr_sat = (w_qr > 5'd15) ? 4'd15 : w_qr[3:0];

  always_comb begin
    o_cmd_type = CMD_QUERYREP;
    o_updn     = UPDN_NONE;
    o_q_nxt    = i_q;
    if (w_qr_sat > i_q) begin
      o_cmd_type = CMD_QUERYADJUST;
      o_updn     = UPDN_UP;
      o_q_nxt    = i_q + 4'd1;
    end else if (w_qr_sat < i_q) begin
      o_cmd_type = CMD_QUERYADJUST;
      o_updn     = UPDN_DOWN;
      o_q_nxt    = i_q - 4'd1;
    end
  end

endmodule

// File: rtl/inventory_q_ctrl.sv
// Purpose: reader-side Q-algorithm round controller (Query, then QueryRep/QueryAdjust per slot).
// Latency: command valid 1 cycle after start, 2 cycles after a slot strobe; done 2 cycles after final strobe.
// Backpressure: command held stable until valid&ready; abort drops the pending command.
// Ports: i_start/i_abort/i_q_init round control; o_cmd_* + i_cmd_ready command handshake;
//        i_slot_valid/i_slot_result slot outcome; o_busy/o_round_done/o_timeout/o_*_cnt status.
module inventory_q_ctrl
  import rfid_inv_pkg::*;
#(
  parameter int C_QTR     = 1,
  parameter int MAX_SLOTS = 65535,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [3:0]       i_q_init,
  output logic             o_cmd_valid,
  input  logic             i_cmd_ready,
  output logic [1:0]       o_cmd_type,
  output logic [3:0]       o_cmd_q,
  output logic [1:0]       o_cmd_updn,
  input  logic             i_slot_valid,
  input  logic [1:0]       i_slot_result,
  output logic             o_busy,
  output logic             o_round_done,
  output logic             o_timeout,
  output logic [CNT_W-1:0] o_slot_cnt,
  output logic [CNT_W-1:0] o_tag_cnt
);

  inv_state_e       r_state, w_state_nxt;
  logic [3:0]       r_q;
  logic [5:0]       r_qfp;
  logic [1:0]       r_result;
  logic [1:0]       r_cmd_type, r_cmd_updn;
  logic [3:0]       r_cmd_q;
  logic [CNT_W-1:0] r_slot_cnt, r_tag_cnt;
  logic             r_timeout;

  logic       w_start, w_hs, w_slot, w_upd, w_stage, w_to;
  logic [5:0] w_qfp_nxt;
  logic [1:0] w_type_nxt, w_updn_nxt;
  logic [3:0] w_q_nxt;

  q_adjust_calc #(.C_QTR(C_QTR)) u_calc (
    .i_qfp      (r_qfp),
    .i_q        (r_q),
    .i_result   (r_result),
    .o_qfp_nxt  (w_qfp_nxt),
    .o_cmd_type (w_type_nxt),
    .o_updn     (w_updn_nxt),
    .o_q_nxt    (w_q_nxt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    o_cmd_valid  = 1'b0;
    o_busy       = 1'b1;
    o_round_done = 1'b0;
    w_start      = 1'b0;
    w_hs         = 1'b0;
    w_slot       = 1'b0;
    w_upd        = 1'b0;
    w_stage      = 1'b0;
    w_to         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_start     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_cmd_valid = 1'b1;
        if (i_cmd_ready) begin
          w_hs        = 1'b1;
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (i_slot_valid) begin
          w_slot      = 1'b1;
          w_state_nxt = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        w_upd = 1'b1;
        // Round termination is decided before any next command is staged.
        if (r_result == SLOT_EMPTY && r_q == 4'd0) begin
          w_state_nxt = ST_DONE;
        end else if (r_slot_cnt == CNT_W'(MAX_SLOTS)) begin
          w_to        = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_stage     = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_DONE: begin
        o_round_done = 1'b1;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Abort wins over any same-cycle handshake, strobe or update.
    if (i_abort && r_state != ST_IDLE) begin
      w_state_nxt = ST_IDLE;
      w_hs        = 1'b0;
      w_slot      = 1'b0;
      w_upd       = 1'b0;
      w_stage     = 1'b0;
      w_to        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= '0;
      r_qfp      <= '0;
      r_result   <= '0;
      r_cmd_type <= '0;
      r_cmd_q    <= '0;
      r_cmd_updn <= '0;
      r_slot_cnt <= '0;
      r_tag_cnt  <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_start) begin
        r_q        <= i_q_init;
        r_qfp      <= {i_q_init, 2'b00};
        r_cmd_type <= CMD_QUERY;
        r_cmd_q    <= i_q_init;
        r_cmd_updn <= UPDN_NONE;
        r_slot_cnt <= '0;
        r_tag_cnt  <= '0;
        r_timeout  <= 1'b0;
      end
      // Q only changes once the encoder has actually taken the adjust.
      if (w_hs && r_cmd_type == CMD_QUERYADJUST) r_q <= r_cmd_q;
      if (w_slot) begin
        r_result   <= i_slot_result;
        r_slot_cnt <= r_slot_cnt + CNT_W'(1);
        if (i_slot_result == SLOT_SINGLE && r_tag_cnt != '1)
          r_tag_cnt <= r_tag_cnt + CNT_W'(1);
      end
      if (w_upd) r_qfp <= w_qfp_nxt;
      if (w_stage) begin
        r_cmd_type <= w_type_nxt;
        r_cmd_q    <= w_q_nxt;
        r_cmd_updn <= w_updn_nxt;
      end
      if (w_to) r_timeout <= 1'b1;
    end
  end

  assign o_cmd_type = r_cmd_type;
  assign o_cmd_q    = r_cmd_q;
  assign o_cmd_updn = r_cmd_updn;
  assign o_timeout  = r_timeout;
  assign o_slot_cnt = r_slot_cnt;
  assign o_tag_cnt  = r_tag_cnt;

endmodule

// File: tb/tb_inventory_q_ctrl.sv
// Bench for inventory_q_ctrl: directed scenarios plus randomized rounds.
// Expected commands and round-end events are queued by a reference model;
// a negedge monitor pops and compares whenever a handshake or done pulse occurs.
module tb_inventory_q_ctrl;

  localparam int C_QTR = 1;
  localparam int MAXS  = 6;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_start = 1'b0;
  logic             i_abort = 1'b0;
  logic [3:0]       i_q_init = '0;
  logic             i_cmd_ready = 1'b0;
  logic             i_slot_valid = 1'b0;
  logic [1:0]       i_slot_result = '0;
  logic             o_cmd_valid, o_busy, o_round_done, o_timeout;
  logic [1:0]       o_cmd_type, o_cmd_updn;
  logic [3:0]       o_cmd_q;
  logic [CNT_W-1:0] o_slot_cnt, o_tag_cnt;

  always #5 clk = ~clk;

  inventory_q_ctrl #(.C_QTR(C_QTR), .MAX_SLOTS(MAXS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (i_start),
    .i_abort      (i_abort),
    .i_q_init     (i_q_init),
    .o_cmd_valid  (o_cmd_valid),
    .i_cmd_ready  (i_cmd_ready),
    .o_cmd_type   (o_cmd_type),
    .o_cmd_q      (o_cmd_q),
    .o_cmd_updn   (o_cmd_updn),
    .i_slot_valid (i_slot_valid),
    .i_slot_result(i_slot_result),
    .o_busy       (o_busy),
    .o_round_done (o_round_done),
    .o_timeout    (o_timeout),
    .o_slot_cnt   (o_slot_cnt),
    .o_tag_cnt    (o_tag_cnt)
  );

  typedef struct {
    bit is_done;
    int typ;
    int q;
    int updn;
    int tmo;
    int slots;
    int tags;
  } exp_t;

  exp_t sbq[$];
  int n_chk = 0, n_pass = 0, n_done = 0;
  int m_q, m_qfp, m_slots, m_tags;

  task automatic chk(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: Q tracked in quarter units, rounded to nearest for the target.
  task automatic model_slot(input int res, output bit fin);
    exp_t e;
    int qr;
    e = '{is_done: 0, typ: 0, q: 0, updn: 0, tmo: 0, slots: 0, tags: 0};
    m_slots++;
    if (res == 1) m_tags++;
    if (res == 0) m_qfp = (m_qfp > C_QTR) ? m_qfp - C_QTR : 0;
    else if (res >= 2) m_qfp = (m_qfp + C_QTR > 60) ? 60 : m_qfp + C_QTR;
    fin = 1'b1;
    if (res == 0 && m_q == 0) begin
      e.is_done = 1;
    end else if (m_slots == MAXS) begin
      e.is_done = 1;
      e.tmo = 1;
    end else begin
      fin = 1'b0;
      qr = (m_qfp + 2) / 4;
      if (qr > 15) qr = 15;
      if (qr > m_q) begin
        m_q++; e.typ = 2; e.updn = 1;
      end else if (qr < m_q) begin
        m_q--; e.typ = 2; e.updn = 2;
      end else begin
        e.typ = 1;
      end
      e.q = m_q;
    end
    e.slots = m_slots;
    e.tags  = m_tags;
    sbq.push_back(e);
  endtask

  task automatic start_round(input int q);
    exp_t e;
    i_q_init = q[3:0];
    i_start  = 1'b1;
    tick();
    i_start  = 1'b0;
    m_q = q; m_qfp = 4 * q; m_slots = 0; m_tags = 0;
    e = '{is_done: 0, typ: 0, q: q, updn: 0, tmo: 0, slots: 0, tags: 0};
    sbq.push_back(e);
  endtask

  // Randomly stalls ready; while stalled, injects strobes/starts that must be ignored.
  task automatic accept_cmd(input int stall_max);
    int n;
    bit ok;
    n = 0; ok = 1'b0;
    while (!ok && n < 40) begin
      if (o_cmd_valid) begin
        i_cmd_ready = ($urandom_range(0, stall_max) == 0);
        if (!i_cmd_ready && $urandom_range(0, 3) == 0) begin
          i_slot_valid  = 1'b1;
          i_slot_result = 2'($urandom_range(0, 3));
        end
        if (!i_cmd_ready && $urandom_range(0, 3) == 0) i_start = 1'b1;
        if (i_cmd_ready) ok = 1'b1;
      end
      tick();
      i_cmd_ready = 1'b0; i_slot_valid = 1'b0; i_start = 1'b0;
      n++;
    end
    if (!ok) chk("cmd_handshake_bound", 0, 1);
  endtask

  task automatic do_slot(input int res, output bit fin);
    i_slot_valid  = 1'b1;
    i_slot_result = res[1:0];
    tick();
    i_slot_valid  = 1'b0;
    model_slot(res, fin);
  endtask

  task automatic abort_round(input bit in_issue);
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    if (in_issue && sbq.size() > 0) sbq.delete(sbq.size() - 1);
    @(negedge clk);
    chk("abort_busy", o_busy, 0);
    chk("abort_valid", o_cmd_valid, 0);
    chk("abort_slot_hold", o_slot_cnt, m_slots);
    chk("abort_tag_hold", o_tag_cnt, m_tags);
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (o_busy && n < 10) begin
      tick();
      n++;
    end
    chk("idle_bound", o_busy, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o_cmd_valid && i_cmd_ready) begin
        if (sbq.size() == 0) chk("cmd_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("cmd_kind", 0, e.is_done);
          chk("cmd_type", o_cmd_type, e.typ);
          chk("cmd_q", o_cmd_q, e.q);
          chk("cmd_updn", o_cmd_updn, e.updn);
        end
      end
      if (o_round_done) begin
        n_done++;
        if (sbq.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("done_kind", 1, e.is_done);
          chk("done_timeout", o_timeout, e.tmo);
          chk("done_slot_cnt", o_slot_cnt, e.slots);
          chk("done_tag_cnt", o_tag_cnt, e.tags);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin;
    bit aborted;
    int d0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_valid", o_cmd_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_round_done, 0);
    chk("rst_timeout", o_timeout, 0);
    chk("rst_type", o_cmd_type, 0);
    chk("rst_q", o_cmd_q, 0);
    chk("rst_updn", o_cmd_updn, 0);
    chk("rst_slot", o_slot_cnt, 0);
    chk("rst_tag", o_tag_cnt, 0);
    tick();
    rst = 1'b0;
    tick();

    // QUERY held through 3 stalled cycles, accepted on the 4th
    start_round(4);
    @(negedge clk);
    chk("query_valid", o_cmd_valid, 1);
    chk("query_type", o_cmd_type, 0);
    chk("query_q", o_cmd_q, 4);
    chk("query_busy", o_busy, 1);
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("query_hold_valid", o_cmd_valid, 1);
      chk("query_hold_q", o_cmd_q, 4);
      chk("query_hold_type", o_cmd_type, 0);
    end
    tick();
    i_cmd_ready = 1'b1;
    tick();
    i_cmd_ready = 1'b0;

    // Two collisions: QueryRep q=4, then QueryAdjust up q=5
    do_slot(2, fin);
    @(negedge clk);
    chk("latency_c1", o_cmd_valid, 0);
    tick();
    @(negedge clk);
    chk("latency_c2", o_cmd_valid, 1);
    tick();
    accept_cmd(0);
    do_slot(2, fin);
    accept_cmd(2);
    chk("two_coll_slot_cnt", o_slot_cnt, 2);
    abort_round(0);

    // q_init=0 and an empty slot ends the round with no command
    start_round(0);
    accept_cmd(1);
    do_slot(0, fin);
    @(negedge clk);
    chk("empty_done_c1", o_round_done, 0);
    chk("empty_valid_c1", o_cmd_valid, 0);
    tick();
    @(negedge clk);
    chk("empty_done_c2", o_round_done, 1);
    chk("empty_valid_c2", o_cmd_valid, 0);
    tick();
    @(negedge clk);
    chk("empty_busy_after", o_busy, 0);
    tick();

    // Q=15 with collisions saturates: QueryRep q=15 each slot
    start_round(15);
    accept_cmd(1);
    for (int i = 0; i < 5; i++) begin
      do_slot(2, fin);
      accept_cmd(1);
    end
    abort_round(0);

    // Slot budget exhaustion with singles
    d0 = n_done;
    start_round(2);
    accept_cmd(1);
    fin = 1'b0;
    for (int i = 0; i < MAXS; i++) begin
      do_slot(1, fin);
      if (!fin) accept_cmd(1);
    end
    wait_idle();
    chk("budget_timeout", o_timeout, 1);
    chk("budget_tags", o_tag_cnt, MAXS);
    chk("budget_slots", o_slot_cnt, MAXS);
    chk("budget_done_pulses", n_done - d0, 1);

    // Abort while a QUERY is stalled, then a clean restart
    d0 = n_done;
    start_round(3);
    @(negedge clk);
    chk("abort_pre_valid", o_cmd_valid, 1);
    tick();
    abort_round(1);
    tick();
    tick();
    chk("abort_no_done", n_done - d0, 0);
    start_round(3);
    @(negedge clk);
    chk("restart_valid", o_cmd_valid, 1);
    chk("restart_type", o_cmd_type, 0);
    chk("restart_q", o_cmd_q, 3);
    chk("restart_timeout_clr", o_timeout, 0);
    tick();
    accept_cmd(0);
    abort_round(0);

    // Randomized rounds
    for (int r = 0; r < 40; r++) begin
      start_round($urandom_range(0, 6));
      accept_cmd(3);
      fin = 1'b0;
      aborted = 1'b0;
      while (!fin && !aborted) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 19) == 0) begin
          abort_round(0);
          aborted = 1'b1;
        end else begin
          do_slot($urandom_range(0, 3), fin);
          if (!fin) begin
            if ($urandom_range(0, 19) == 0) begin
              tick();
              abort_round(1);
              aborted = 1'b1;
            end else begin
              accept_cmd(3);
            end
          end
        end
      end
      wait_idle();
      chk("sb_drained", sbq.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
